// File: rtl/trace_capture_buffer.sv
// Retire-trace recorder: captures pc/inst pairs into a circular buffer for a bounded
// number of cycles after reset, drained through a first-word-fall-through valid/ready port.
module trace_capture_buffer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 1500,
    parameter int CNT_W       = 16
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       en,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [DATA_W-1:0]          inst,
    input  logic                       mode,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [ADDR_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_inst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic                       done,
    output logic [CNT_W-1:0]           cycle_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(CYCLE_LIMIT);
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(DEPTH);

    typedef enum logic {
        RUN,
        FROZEN
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cycle_cnt_q, cycle_cnt_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic [ADDR_W+DATA_W-1:0]    mem_q [DEPTH];

    logic                        push;
    logic                        pop;
    logic                        is_full;
    logic                        mem_we;

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;

        push    = en && (state_q == RUN);
        pop     = (count_q != '0) && rd_ready;
        is_full = (count_q == DEPTH_CNT);

        // The edge that reaches the limit is still a capture cycle; freezing applies after it.
        if (state_q == RUN) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (cycle_cnt_d == LIMIT) begin
                state_d = FROZEN;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CW'(1);
        end

        if (push) begin
            if (is_full && !pop) begin
                overflow_d = 1'b1;
                if (mode) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = pop ? count_q : count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= RUN;
            cycle_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is intentionally left uninitialised by reset; only the pointers matter.
    always_ff @(posedge clk_in) begin
        if (!reset && mem_we) begin
            mem_q[wr_ptr_q] <= {pc, inst};
        end
    end

    assign rd_valid  = (count_q != '0);
    assign rd_pc     = mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];
    assign rd_inst   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign count     = count_q;
    assign full      = (count_q == DEPTH_CNT);
    assign overflow  = overflow_q;
    assign done      = (state_q == FROZEN);
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer: a queue-based reference model tracks the
// expected buffer contents while a negedge monitor compares every DUT output against it.
module tb_trace_capture_buffer;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 4;
    localparam int CYCLE_LIMIT = 40;
    localparam int CNT_W       = 16;

    logic                  clk_in = 1'b0;
    logic                  reset = 1'b1;
    logic                  en = 1'b0;
    logic                  mode = 1'b0;
    logic                  rd_ready = 1'b0;
    logic [ADDR_W-1:0]     pc = '0;
    logic [DATA_W-1:0]     inst = '0;
    logic                  rd_valid;
    logic [ADDR_W-1:0]     rd_pc;
    logic [DATA_W-1:0]     rd_inst;
    logic [$clog2(DEPTH):0] count;
    logic                  full;
    logic                  overflow;
    logic                  done;
    logic [CNT_W-1:0]      cycle_cnt;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t exp_q[$];
    int     m_cyc = 0;
    bit     m_ovf = 1'b0;
    bit     check_en = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     pop_seen = 0;

    trace_capture_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .CYCLE_LIMIT(CYCLE_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .reset(reset), .en(en), .pc(pc), .inst(inst),
        .mode(mode), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_inst(rd_inst), .count(count), .full(full), .overflow(overflow),
        .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic rr,
                                 input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] i);
        reset    = r;
        en       = e;
        mode     = m;
        rd_ready = rr;
        pc       = p;
        inst     = i;
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: a bounded FIFO of captured pairs plus a capture window of CYCLE_LIMIT cycles.
    initial begin
        forever begin
            @(posedge clk_in);
            if (reset) begin
                exp_q.delete();
                m_cyc    = 0;
                m_ovf    = 1'b0;
                check_en = 1'b1;
            end else begin
                if (exp_q.size() > 0 && rd_ready) begin
                    void'(exp_q.pop_front());
                end
                if (en && m_cyc < CYCLE_LIMIT) begin
                    if (exp_q.size() == DEPTH) begin
                        m_ovf = 1'b1;
                        if (mode) begin
                            void'(exp_q.pop_front());
                            exp_q.push_back('{pc: pc, inst: inst});
                        end
                    end else begin
                        exp_q.push_back('{pc: pc, inst: inst});
                    end
                end
                if (m_cyc < CYCLE_LIMIT) begin
                    m_cyc++;
                end
            end
        end
    end

    // Monitor: compares the presented head entry and status outputs each cycle.
    initial begin
        forever begin
            @(negedge clk_in);
            if (check_en) begin
                checkOutput("rd_valid", 64'(rd_valid), 64'(exp_q.size() > 0));
                checkOutput("count", 64'(count), 64'(exp_q.size()));
                checkOutput("full", 64'(full), 64'(exp_q.size() == DEPTH));
                checkOutput("overflow", 64'(overflow), 64'(m_ovf));
                checkOutput("done", 64'(done), 64'(m_cyc == CYCLE_LIMIT));
                checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
                if (rd_valid && exp_q.size() > 0) begin
                    checkOutput("rd_pc", 64'(rd_pc), 64'(exp_q[0].pc));
                    checkOutput("rd_inst", 64'(rd_inst), 64'(exp_q[0].inst));
                end
                if (rd_valid && rd_ready && !reset) begin
                    pop_seen++;
                end
            end
        end
    end

    initial begin
        // In-order drain after three pushes.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 32'(k * 4), 32'(k + 1));
        checkOutput("p1_count", 64'(count), 64'd3);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("p1_drained", 64'(rd_valid), 64'd0);
        checkOutput("p1_overflow", 64'(overflow), 64'd0);

        // Stop-on-full keeps the oldest four.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0, 32'(k * 4), 32'(k + 1));
        checkOutput("p2_full", 64'(full), 64'd1);
        checkOutput("p2_overflow", 64'(overflow), 64'd1);
        checkOutput("p2_head", 64'(rd_pc), 64'h0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0, 0);

        // Overwrite mode keeps the newest four.
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1, 0, 32'(k * 4), 32'(k + 1));
        checkOutput("p3_count", 64'(count), 64'd4);
        checkOutput("p3_head", 64'(rd_pc), 64'h8);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 1, 0, 0);

        // Simultaneous push and pop while full.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 32'(k * 4), 32'(k + 1));
        for (int k = 4; k < 7; k++) applyStimulus(0, 1, 0, 1, 32'(k * 4), 32'(k + 1));
        checkOutput("p4_count", 64'(count), 64'd4);
        checkOutput("p4_overflow", 64'(overflow), 64'd0);
        checkOutput("p4_head", 64'(rd_pc), 64'hC);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0, 0);

        // Capture window: exactly CYCLE_LIMIT entries, then frozen.
        applyStimulus(1, 0, 0, 0, 0, 0);
        pop_seen = 0;
        for (int k = 0; k < CYCLE_LIMIT + 10; k++)
            applyStimulus(0, 1, 0, 1, 32'(32'h100 + k * 4), 32'(k));
        checkOutput("p5_done", 64'(done), 64'd1);
        checkOutput("p5_cycle_cnt", 64'(cycle_cnt), 64'(CYCLE_LIMIT));
        checkOutput("p5_captured", 64'(pop_seen), 64'(CYCLE_LIMIT));
        checkOutput("p5_empty", 64'(rd_valid), 64'd0);

        // Reset in the middle of a drain.
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 1, 0, 32'(k * 4), 32'(k + 1));
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("p6_pre_count", 64'(count), 64'd3);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("p6_count", 64'(count), 64'd0);
        checkOutput("p6_valid", 64'(rd_valid), 64'd0);
        checkOutput("p6_done", 64'(done), 64'd0);
        checkOutput("p6_overflow", 64'(overflow), 64'd0);
        checkOutput("p6_cycle_cnt", 64'(cycle_cnt), 64'd0);
        applyStimulus(0, 1, 0, 0, 32'h200, 32'h55);
        applyStimulus(0, 1, 0, 0, 32'h204, 32'h66);
        checkOutput("p6_resume_head", 64'(rd_pc), 64'h200);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1, 0, 0);

        // Randomised traffic across modes with occasional resets.
        for (int seg = 0; seg < 3; seg++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            for (int k = 0; k < 80; k++) begin
                applyStimulus(1'($urandom_range(0, 99) < 2),
                              1'($urandom_range(0, 99) < 70),
                              (seg == 2) ? 1'($urandom_range(0, 1)) : 1'(seg),
                              1'($urandom_range(0, 99) < 40),
                              $urandom, $urandom);
            end
        end

        applyStimulus(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Synthesizable retire-trace recorder for the single-cycle CPU top level.
- Taps the per-cycle pc/inst stream and stores up to DEPTH entries in a circular buffer, with a configurable cycle budget after which capture freezes.
- Drained through a valid/ready read port by a debug UART or a bench checker.
- Replaces the fixed-count, file-dump tracing done in simulation; adds selectable stop-on-full or overwrite-oldest modes.

Parameters:
- ADDR_W, 32, width of captured pc.
- DATA_W, 32, width of captured instruction word.
- DEPTH, 16, buffer entries; power of two, >= 2.
- CYCLE_LIMIT, 1500, cycles after reset during which capture is allowed.
- CNT_W, 16, width of the cycle counter; must hold CYCLE_LIMIT.

Ports:
- clk_in  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  capture strobe; pc/inst valid this cycle.
- pc  in  ADDR_W  pc of the retiring instruction.
- inst  in  DATA_W  instruction word.
- mode  in  1  0 = stop-on-full (drop new entries), 1 = overwrite oldest.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  buffer non-empty.
- rd_pc  out  ADDR_W  pc at head.
- rd_inst  out  DATA_W  inst at head.
- count  out  clog2(DEPTH)+1  entries held.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; an entry was dropped or overwritten.
- done  out  1  cycle budget exhausted; capture frozen.
- cycle_cnt  out  CNT_W  cycles elapsed since reset, saturating.

Behaviour:
- Reset (synchronous, any cycle, including mid-drain):
  - wr_ptr, rd_ptr, count, cycle_cnt, overflow, done all cleared to 0.
  - rd_valid = 0, full = 0.
  - Buffer contents not cleared; rd_pc/rd_inst are don't-care while rd_valid = 0.
- State machine, two states: RUN and FROZEN.
  - RUN: cycle_cnt increments by 1 every non-reset cycle.
  - RUN -> FROZEN on the edge where cycle_cnt becomes CYCLE_LIMIT.
  - FROZEN: cycle_cnt holds at CYCLE_LIMIT, done = 1, all captures are ignored. Exit only via reset.
  - Consequence: at most CYCLE_LIMIT cycles (cycle_cnt 0..CYCLE_LIMIT-1) can capture.
- Push:
  - Accepted when en = 1 and state = RUN.
  - Writes {pc, inst} at wr_ptr, then wr_ptr++ modulo DEPTH. Pointers wrap naturally (log2 DEPTH bits).
- Pop:
  - Occurs when rd_valid && rd_ready; rd_ptr++ modulo DEPTH.
  - rd_pc/rd_inst are first-word-fall-through: head entry visible combinationally from storage while rd_valid = 1.
  - Pop on empty is ignored.
- Push when full, no pop:
  - mode 0: entry dropped; pointers and count unchanged; overflow <= 1.
  - mode 1: entry written at wr_ptr; wr_ptr++ and rd_ptr++ (oldest lost); count stays DEPTH; overflow <= 1.
- Push and pop in the same cycle:
  - Both happen in either mode; count unchanged; no overflow, even when full.
  - When empty, only the push takes effect (pop ignored); count becomes 1 and rd_valid rises next cycle.
- Count update: count += push_accepted - pop_done. Overwrite does not change count.
- Latency: a captured entry is visible at rd_* one cycle after the capture edge.
- mode is sampled every cycle; a change takes effect on the next push.
- overflow is sticky until reset.

Test Plan:
- DEPTH=4, mode=0: push pc=0x0,0x4,0x8 with inst=0x1,0x2,0x3, then rd_ready=1 -> rd_pc reads 0x0,0x4,0x8 in order; count 3->0; rd_valid drops after third pop; overflow=0.
- DEPTH=4, mode=0: push 6 entries (pc 0x0..0x14), no reads -> full=1, count=4, overflow=1; drain yields pc 0x0,0x4,0x8,0xC.
- DEPTH=4, mode=1: push 6 entries (pc 0x0..0x14) -> count=4, overflow=1; drain yields 0x8,0xC,0x10,0x14.
- DEPTH=4, full, en=1 with rd_ready=1 for 3 cycles -> count stays 4, overflow stays 0, pops return oldest entries in order.
- CYCLE_LIMIT=10, DEPTH=16, en=1 every cycle from reset release -> exactly 10 entries captured, done=1 from cycle 10, cycle_cnt saturates at 10, later en ignored.
- Assert reset for one cycle with count=3 mid-drain -> next cycle count=0, rd_valid=0, done=0, overflow=0, cycle_cnt=0; capture resumes correctly.
